// File: rtl/bht_predictor_pkg.sv
// Shared definitions for the branch history table predictor.
package bht_predictor_pkg;

    // Instruction memory word-address width; the predictor PC width follows it.
    localparam int unsigned IMEM_AW    = 10;
    localparam int unsigned BHT_PC_W   = IMEM_AW;
    localparam int unsigned BHT_STAT_W = 16;

    // Operation applied by the saturating counter.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

endpackage : bht_predictor_pkg

// File: rtl/bht_sat_counter.sv
// Combinational saturating increment/decrement next-value generator.
module bht_sat_counter
    import bht_predictor_pkg::*;
#(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] cnt_i,
    input  cnt_op_e      op_i,
    output logic [W-1:0] cnt_c
);

    // Step toward the requested direction, sticking at all-ones or zero.
    always_comb begin
        cnt_c = cnt_i;
        unique case (op_i)
            CNT_INC: if (cnt_i != '1) cnt_c = cnt_i + W'(1);
            CNT_DEC: if (cnt_i != '0) cnt_c = cnt_i - W'(1);
            default: cnt_c = cnt_i;
        endcase
    end

endmodule : bht_sat_counter

// File: rtl/bht_predictor.sv
// Branch history table with per-entry target: fetch-side lookup, resolve-side update, statistics.
module bht_predictor
    import bht_predictor_pkg::*;
#(
    parameter int unsigned PC_W    = BHT_PC_W,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned STAT_W  = BHT_STAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clear,
    input  logic              lookup_valid,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_pc,
    input  logic              upd_en,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_mispredict,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W;
    localparam logic [CNT_W-1:0] WEAK_T = CNT_W'(1) << (CNT_W - 1);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    logic [CNT_W-1:0] cnt_q    [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [PC_W-1:0]  target_d [ENTRIES];
    logic [CNT_W-1:0] cnt_d    [ENTRIES];

    logic [STAT_W-1:0] stat_lookups_q, stat_hits_q, stat_mispredicts_q;
    logic [STAT_W-1:0] stat_lookups_d, stat_hits_d, stat_mispredicts_d;

    logic [IDX_W-1:0] lu_idx, upd_idx;
    logic [TAG_W-1:0] lu_tag, upd_tag;
    logic             upd_hit_c;
    logic [CNT_W-1:0] upd_cnt_c;
    cnt_op_e          upd_op_c, lk_op_c, hit_op_c, mp_op_c;

    assign lu_idx  = lookup_pc[IDX_W-1:0];
    assign lu_tag  = lookup_pc[PC_W-1:IDX_W];
    assign upd_idx = upd_pc[IDX_W-1:0];
    assign upd_tag = upd_pc[PC_W-1:IDX_W];

    // Fetch-side lookup from registered state; no bypass of a same-cycle update.
    always_comb begin
        pred_hit   = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
        pred_taken = pred_hit && cnt_q[lu_idx][CNT_W-1];
        pred_pc    = pred_taken ? target_q[lu_idx] : lookup_pc + PC_W'(1);
    end

    // Direction counter step for the entry being resolved.
    always_comb begin
        upd_hit_c = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_op_c  = CNT_HOLD;
        if (upd_hit_c) upd_op_c = upd_taken ? CNT_INC : CNT_DEC;
    end

    bht_sat_counter #(.W(CNT_W)) u_dir_cnt (
        .cnt_i (cnt_q[upd_idx]),
        .op_i  (upd_op_c),
        .cnt_c (upd_cnt_c)
    );

    // Table next state: clear beats update, miss-taken allocates, en=0 freezes.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (en) begin
            if (clear) begin
                for (int i = 0; i < int'(ENTRIES); i++) begin
                    valid_d[i]  = 1'b0;
                    tag_d[i]    = '0;
                    target_d[i] = '0;
                    cnt_d[i]    = WEAK_T;
                end
            end else if (upd_en) begin
                if (upd_hit_c) begin
                    cnt_d[upd_idx] = upd_cnt_c;
                    if (upd_taken) target_d[upd_idx] = upd_target;
                end else if (upd_taken) begin
                    valid_d[upd_idx]  = 1'b1;
                    tag_d[upd_idx]    = upd_tag;
                    target_d[upd_idx] = upd_target;
                    cnt_d[upd_idx]    = WEAK_T;
                end
            end
        end
    end

    // Statistic increment requests; a clear does not suppress the mispredict count.
    always_comb begin
        lk_op_c  = (en && lookup_valid)             ? CNT_INC : CNT_HOLD;
        hit_op_c = (en && lookup_valid && pred_hit) ? CNT_INC : CNT_HOLD;
        mp_op_c  = (en && upd_en && upd_mispredict) ? CNT_INC : CNT_HOLD;
    end

    bht_sat_counter #(.W(STAT_W)) u_stat_lk  (.cnt_i(stat_lookups_q),     .op_i(lk_op_c),  .cnt_c(stat_lookups_d));
    bht_sat_counter #(.W(STAT_W)) u_stat_hit (.cnt_i(stat_hits_q),        .op_i(hit_op_c), .cnt_c(stat_hits_d));
    bht_sat_counter #(.W(STAT_W)) u_stat_mp  (.cnt_i(stat_mispredicts_q), .op_i(mp_op_c),  .cnt_c(stat_mispredicts_d));

    // State registers with asynchronous reset to an empty, weakly-taken table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= WEAK_T;
            end
            stat_lookups_q     <= '0;
            stat_hits_q        <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            cnt_q              <= cnt_d;
            stat_lookups_q     <= stat_lookups_d;
            stat_hits_q        <= stat_hits_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_lookups     = stat_lookups_q;
    assign stat_hits        = stat_hits_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule : bht_predictor

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor against a behavioural table model.
module tb_bht_predictor;

    logic       clk = 1'b0;
    logic       rst_n, rst2_n;
    logic       en, clear, lookup_valid;
    logic [9:0] lookup_pc;
    logic       upd_en, upd_taken, upd_mispredict;
    logic [9:0] upd_pc, upd_target;
    logic       pred_hit, pred_taken;
    logic [9:0] pred_pc;
    logic [15:0] stat_lookups, stat_hits, stat_mispredicts;
    logic       s_pred_hit, s_pred_taken;
    logic [9:0] s_pred_pc;
    logic [3:0] s_lookups, s_hits, s_mispredicts;

    int checks = 0;
    int errors = 0;

    // Reference model: plain per-index arrays and integer statistics.
    bit m_valid [16];
    int m_tag   [16];
    int m_tgt   [16];
    int m_cnt   [16];
    int m_lk, m_ht, m_mp;

    always #5 clk = ~clk;

    bht_predictor dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_lookups(stat_lookups), .stat_hits(stat_hits),
        .stat_mispredicts(stat_mispredicts)
    );

    bht_predictor #(.STAT_W(4)) dut_s4 (
        .clk(clk), .rst_n(rst2_n), .en(en), .clear(clear),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_hit(s_pred_hit), .pred_taken(s_pred_taken), .pred_pc(s_pred_pc),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_lookups(s_lookups), .stat_hits(s_hits),
        .stat_mispredicts(s_mispredicts)
    );

    function automatic bit m_hit(int pc);
        return m_valid[pc % 16] && (m_tag[pc % 16] == pc / 16);
    endfunction

    // Expected {hit, taken, next pc} for a lookup of pc.
    function automatic logic [11:0] exp_pred(int pc);
        bit h, t;
        int npc;
        h   = m_hit(pc);
        t   = h && (m_cnt[pc % 16] >= 2);
        npc = t ? m_tgt[pc % 16] : (pc + 1) % 1024;
        return {h, t, 10'(npc)};
    endfunction

    function automatic logic [47:0] exp_stats();
        return {16'(m_lk), 16'(m_ht), 16'(m_mp)};
    endfunction

    function automatic void model_clear_table();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 2;
        end
    endfunction

    // Advance one clock; the model applies the rules to the pre-edge inputs.
    task automatic tick();
        bit pre_hit;
        int i;
        pre_hit = m_hit(int'(lookup_pc));
        @(posedge clk);
        if (en) begin
            if (lookup_valid) m_lk = (m_lk < 65535) ? m_lk + 1 : m_lk;
            if (lookup_valid && pre_hit) m_ht = (m_ht < 65535) ? m_ht + 1 : m_ht;
            if (upd_en && upd_mispredict) m_mp = (m_mp < 65535) ? m_mp + 1 : m_mp;
            if (clear) model_clear_table();
            else if (upd_en) begin
                i = int'(upd_pc) % 16;
                if (m_hit(int'(upd_pc))) begin
                    if (upd_taken) begin
                        m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
                        m_tgt[i] = int'(upd_target);
                    end else begin
                        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
                    end
                end else if (upd_taken) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = int'(upd_pc) / 16;
                    m_tgt[i]   = int'(upd_target);
                    m_cnt[i]   = 2;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        en = 1'b1; clear = 1'b0; lookup_valid = 1'b0; lookup_pc = '0;
        upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    endtask

    task automatic update(input logic [9:0] pc, input logic tk, input logic [9:0] tgt);
        upd_en = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        tick();
        upd_en = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0; rst2_n = 1'b0;
        model_clear_table();
        m_lk = 0; m_ht = 0; m_mp = 0;
        lookup_pc = 10'h005;
        #3;
        checks++;
        if ({pred_hit, pred_taken, pred_pc} !== 12'h006) begin
            errors++; $display("FAIL reset_pred: got %h exp 006", {pred_hit, pred_taken, pred_pc});
        end
        checks++;
        if ({stat_lookups, stat_hits, stat_mispredicts} !== 48'h0) begin
            errors++; $display("FAIL reset_stats: got %h exp 0", {stat_lookups, stat_hits, stat_mispredicts});
        end
        lookup_pc = 10'h3FF;
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_pc} !== 12'h000) begin
            errors++; $display("FAIL reset_wrap: got %h exp 000", {pred_hit, pred_taken, pred_pc});
        end
        @(negedge clk);
        rst_n = 1'b1; rst2_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alloc();
        idle();
        lookup_valid = 1'b1; lookup_pc = 10'h005;
        update(10'h005, 1'b1, 10'h020);
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_pc} !== 12'hC20) begin
            errors++; $display("FAIL alloc_hit: got %h exp C20", {pred_hit, pred_taken, pred_pc});
        end
        lookup_pc = 10'h015;
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_pc} !== 12'h016) begin
            errors++; $display("FAIL alloc_other_tag: got %h exp 016", {pred_hit, pred_taken, pred_pc});
        end
        checks++;
        if ({stat_lookups, stat_hits, stat_mispredicts} !== exp_stats()) begin
            errors++; $display("FAIL alloc_stats: got %h exp %h", {stat_lookups, stat_hits, stat_mispredicts}, exp_stats());
        end
    endtask

    task automatic test_saturation();
        idle();
        lookup_pc = 10'h005;
        for (int k = 0; k < 3; k++) update(10'h005, 1'b1, 10'h020);
        update(10'h005, 1'b0, 10'h000);
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_pc} !== 12'hC20) begin
            errors++; $display("FAIL sat_top_then_dec: got %h exp C20", {pred_hit, pred_taken, pred_pc});
        end
        update(10'h005, 1'b0, 10'h000);
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_pc} !== 12'h806) begin
            errors++; $display("FAIL sat_weak_nt: got %h exp 806", {pred_hit, pred_taken, pred_pc});
        end
        for (int k = 0; k < 3; k++) update(10'h005, 1'b0, 10'h000);
        update(10'h005, 1'b1, 10'h020);
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_pc} !== 12'h806) begin
            errors++; $display("FAIL sat_floor: got %h exp 806", {pred_hit, pred_taken, pred_pc});
        end
        checks++;
        if ({pred_hit, pred_taken, pred_pc} !== exp_pred(5)) begin
            errors++; $display("FAIL sat_model: got %h exp %h", {pred_hit, pred_taken, pred_pc}, exp_pred(5));
        end
    endtask

    task automatic test_same_cycle();
        idle();
        lookup_pc = 10'h007;
        upd_en = 1'b1; upd_pc = 10'h007; upd_taken = 1'b1; upd_target = 10'h100;
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_pc} !== 12'h008) begin
            errors++; $display("FAIL same_cycle_pre: got %h exp 008", {pred_hit, pred_taken, pred_pc});
        end
        tick();
        upd_en = 1'b0;
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_pc} !== 12'hD00) begin
            errors++; $display("FAIL same_cycle_post: got %h exp D00", {pred_hit, pred_taken, pred_pc});
        end
    endtask

    task automatic test_clear();
        logic [15:0] lk0, ht0, mp0;
        idle();
        lk0 = 16'(m_lk); ht0 = 16'(m_ht); mp0 = 16'(m_mp);
        clear = 1'b1; upd_mispredict = 1'b1;
        update(10'h005, 1'b1, 10'h040);
        clear = 1'b0; upd_mispredict = 1'b0;
        lookup_pc = 10'h005;
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_pc} !== 12'h006) begin
            errors++; $display("FAIL clear_miss: got %h exp 006", {pred_hit, pred_taken, pred_pc});
        end
        checks++;
        if ({stat_lookups, stat_hits, stat_mispredicts} !== {lk0, ht0, 16'(mp0 + 16'd1)}) begin
            errors++; $display("FAIL clear_stats: got %h exp %h", {stat_lookups, stat_hits, stat_mispredicts}, {lk0, ht0, 16'(mp0 + 16'd1)});
        end
        lookup_pc = 10'h007;
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_pc} !== 12'h008) begin
            errors++; $display("FAIL clear_all: got %h exp 008", {pred_hit, pred_taken, pred_pc});
        end
    endtask

    task automatic test_enable();
        logic [47:0] st0;
        idle();
        update(10'h005, 1'b1, 10'h020);
        st0 = {stat_lookups, stat_hits, stat_mispredicts};
        en = 1'b0; lookup_valid = 1'b1; lookup_pc = 10'h005;
        upd_en = 1'b1; upd_taken = 1'b1; upd_target = 10'h0AA; upd_mispredict = 1'b1;
        for (int k = 0; k < 4; k++) begin
            upd_pc = (k == 0) ? 10'h009 : 10'h005;
            clear = (k == 2);
            tick();
        end
        idle();
        checks++;
        if ({stat_lookups, stat_hits, stat_mispredicts} !== st0) begin
            errors++; $display("FAIL en_stats: got %h exp %h", {stat_lookups, stat_hits, stat_mispredicts}, st0);
        end
        lookup_pc = 10'h005;
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_pc} !== 12'hC20) begin
            errors++; $display("FAIL en_table_5: got %h exp C20", {pred_hit, pred_taken, pred_pc});
        end
        lookup_pc = 10'h009;
        #1;
        checks++;
        if ({pred_hit, pred_taken, pred_pc} !== 12'h00A) begin
            errors++; $display("FAIL en_table_9: got %h exp 00A", {pred_hit, pred_taken, pred_pc});
        end
    endtask

    task automatic test_stat_sat();
        idle();
        @(negedge clk); rst2_n = 1'b0;
        @(negedge clk); rst2_n = 1'b1;
        @(posedge clk); #1;
        update(10'h005, 1'b1, 10'h020);
        lookup_valid = 1'b1; lookup_pc = 10'h005;
        for (int k = 0; k < 20; k++) tick();
        idle();
        lookup_pc = 10'h005;
        #1;
        checks++;
        if ({s_lookups, s_hits, s_mispredicts} !== 12'hFF0) begin
            errors++; $display("FAIL stat4_sat: got %h exp FF0", {s_lookups, s_hits, s_mispredicts});
        end
        checks++;
        if ({s_pred_hit, s_pred_taken, s_pred_pc} !== 12'hC20) begin
            errors++; $display("FAIL stat4_pred: got %h exp C20", {s_pred_hit, s_pred_taken, s_pred_pc});
        end
        checks++;
        if ({stat_lookups, stat_hits, stat_mispredicts} !== exp_stats()) begin
            errors++; $display("FAIL stat16_cont: got %h exp %h", {stat_lookups, stat_hits, stat_mispredicts}, exp_stats());
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            en             = ($urandom_range(0, 7) != 0);
            clear          = ($urandom_range(0, 39) == 0);
            lookup_valid   = 1'($urandom);
            lookup_pc      = ($urandom_range(0, 9) == 0) ? 10'($urandom)
                                                         : {6'($urandom_range(0, 2)), 4'($urandom)};
            upd_en         = 1'($urandom);
            upd_pc         = {6'($urandom_range(0, 2)), 4'($urandom)};
            upd_taken      = ($urandom_range(0, 2) != 0);
            upd_target     = 10'($urandom);
            upd_mispredict = 1'($urandom);
            #1;
            checks++;
            if ({pred_hit, pred_taken, pred_pc} !== exp_pred(int'(lookup_pc))) begin
                errors++; $display("FAIL rand_pred[%0d]: pc %h got %h exp %h", k, lookup_pc, {pred_hit, pred_taken, pred_pc}, exp_pred(int'(lookup_pc)));
            end
            checks++;
            if ({stat_lookups, stat_hits, stat_mispredicts} !== exp_stats()) begin
                errors++; $display("FAIL rand_stats[%0d]: got %h exp %h", k, {stat_lookups, stat_hits, stat_mispredicts}, exp_stats());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_saturation();
        test_same_cycle();
        test_clear();
        test_enable();
        test_stat_sat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bht_predictor
